// File: rtl/instruction_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_queue_pkg
// Brief    : Shared fetch-stage constants and the buffered fetch entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          DEF_DEPTH  = 4;
    localparam int          DEF_ADDR_W = 9;
    localparam int          ENTRY_W    = 64;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : Synchronous FIFO of fetch entries with flush and combinational head.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import instruction_fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_pop  = pop && (count_q != '0);
    // A full FIFO only accepts a push when a pop frees a slot on the same edge.
    assign w_do_push = push && ((count_q != C_FULL) || w_do_pop);

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (w_do_push) begin
                mem_d[wptr_q] = push_entry;
                wptr_d        = wptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rptr_q];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_queue
// Brief    : Fetch PC, credit-based imem requests, entry buffering and redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = DEF_DEPTH,
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   Reset,
    output logic                   imem_req,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   imem_rvalid,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   deq,
    output logic                   out_valid,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_pc4,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic             pending_q, pending_d;
    logic [CNT_W:0]   w_occupancy;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    // Credit counts the in-flight request so a response always has a slot.
    assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, pending_q};
    assign w_issue     = !Reset && !redirect && (w_occupancy < C_DEPTH);
    assign w_push      = imem_rvalid && pending_q && !redirect;
    assign w_pop       = deq && !redirect;

    assign w_push_entry.instr = imem_rdata;
    assign w_push_entry.pc    = pend_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pending_d  = pending_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            pending_d  = 1'b0;
        end else if (w_issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pend_pc_d  = fetch_pc_q;
            pending_d  = 1'b1;
        end else if (w_push) begin
            pending_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            pending_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pending_q  <= pending_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (Reset),
        .flush      (redirect),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .count      (w_count),
        .head       (w_head)
    );

    assign imem_req  = w_issue;
    assign imem_addr = fetch_pc_q[ADDR_W-1:0];
    assign count     = w_count;

    // An empty queue presents a NOP at PC 0 so IF/ID never sees stale data.
    assign out_valid = (w_count != '0);
    assign out_instr = out_valid ? w_head.instr : NOP_INSTR;
    assign out_pc    = out_valid ? w_head.pc    : 32'd0;
    assign out_pc4   = out_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_queue
// Brief    : Directed self-checking bench for instruction_fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              Reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_rvalid;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              deq;
    logic              out_valid;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [31:0]       out_pc4;
    logic [2:0]        count;
    logic              inject;

    int errors = 0;
    int checks = 0;

    instruction_fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq         (deq),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hC0DE_0000 | {23'd0, a[8:0]};
    endfunction

    // One-cycle-latency memory; inject forces a response with no request.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
    end
    always @(posedge clk) begin
        imem_rvalid <= imem_req | inject;
        imem_rdata  <= inject ? 32'hDEAD_BEEF : word_at({23'd0, imem_addr});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b1; deq = 1'b0; redirect = 1'b0; inject = 1'b0;
        @(negedge clk);
        Reset = 1'b0;
    endtask

    logic [31:0] exp_pc;
    int          pops;

    initial begin
        Reset = 1'b1; deq = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inject = 1'b0;
        #1;
        chk("rst_req",   imem_req,  0);
        chk("rst_valid", out_valid, 0);
        chk("rst_instr", out_instr, 32'h0000_0013);
        chk("rst_pc",    out_pc,    0);
        chk("rst_pc4",   out_pc4,   4);
        chk("rst_count", count,     0);

        // Streaming with deq held high
        do_reset();
        deq = 1'b1;
        #1;
        chk("s_c0_req",   imem_req,  1);
        chk("s_c0_addr",  imem_addr, 0);
        chk("s_c0_valid", out_valid, 0);
        @(negedge clk);
        chk("s_c1_valid", out_valid, 0);
        chk("s_c1_addr",  imem_addr, 4);
        @(negedge clk);
        chk("s_c2_valid", out_valid, 1);
        chk("s_c2_pc",    out_pc,    0);
        chk("s_c2_pc4",   out_pc4,   4);
        chk("s_c2_instr", out_instr, word_at(0));
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("s_pc",    out_pc,    32'(4 * i));
            chk("s_instr", out_instr, word_at(32'(4 * i)));
        end

        // Fill without dequeue, then resume
        do_reset();
        repeat (10) @(negedge clk);
        chk("f_count", count,    4);
        chk("f_req",   imem_req, 0);
        chk("f_head",  out_pc,   0);
        deq = 1'b1;
        @(negedge clk);
        chk("f_resume_req",  imem_req,  1);
        chk("f_resume_addr", imem_addr, 16);
        chk("f_count3",      count,     3);
        chk("f_pc4",         out_pc,    4);
        @(negedge clk);
        chk("f_pc8",  out_pc, 8);
        @(negedge clk);
        chk("f_pc12", out_pc, 12);
        @(negedge clk);
        chk("f_pc16",    out_pc,    16);
        chk("f_instr16", out_instr, word_at(16));

        // Redirect with two entries and a response in flight
        do_reset();
        repeat (3) @(negedge clk);
        chk("r_count_pre", count, 2);
        redirect = 1'b1; redirect_pc = 32'h40; inject = 1'b1;
        #1;
        chk("r_req_blocked", imem_req, 0);
        @(negedge clk);
        redirect = 1'b0; inject = 1'b0;
        #1;
        chk("r_count0", count,     0);
        chk("r_valid0", out_valid, 0);
        chk("r_req",    imem_req,  1);
        chk("r_addr",   imem_addr, 32'h40);
        @(negedge clk);
        chk("r_stale_drop", count, 0);
        @(negedge clk);
        chk("r_valid", out_valid, 1);
        chk("r_pc",    out_pc,    32'h40);
        chk("r_instr", out_instr, word_at(32'h40));

        // Misaligned redirect target
        redirect = 1'b1; redirect_pc = 32'h47;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("m_addr",  imem_addr, 32'h44);
        chk("m_count", count,     0);
        repeat (2) @(negedge clk);
        chk("m_pc",    out_pc,    32'h44);
        chk("m_pc4",   out_pc4,   32'h48);
        chk("m_instr", out_instr, word_at(32'h44));

        // Simultaneous push/pop and order across pointer wrap
        do_reset();
        repeat (3) @(negedge clk);
        chk("w_count_pre", count, 2);
        chk("w_pc0", out_pc, 0);
        deq = 1'b1;
        @(negedge clk);
        chk("w_count_hold", count, 2);
        exp_pc = 32'd4;
        pops   = 1;
        for (int c = 0; c < 200 && pops < 3 * DEPTH; c++) begin
            if (deq && out_valid) begin
                chk("w_pc",    out_pc,    exp_pc);
                chk("w_instr", out_instr, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            @(negedge clk);
            deq = ~deq;
        end
        chk("w_pops_done", pops, 3 * DEPTH);
        deq = 1'b0;

        // Reset mid-operation with a late response after release
        do_reset();
        repeat (4) @(negedge clk);
        chk("x_count_pre", count, 3);
        Reset = 1'b1; inject = 1'b1;
        #1;
        chk("x_count", count,     0);
        chk("x_valid", out_valid, 0);
        chk("x_req",   imem_req,  0);
        chk("x_instr", out_instr, 32'h0000_0013);
        chk("x_pc",    out_pc,    0);
        chk("x_pc4",   out_pc4,   4);
        @(negedge clk);
        Reset = 1'b0; inject = 1'b0;
        #1;
        chk("x_restart_req",  imem_req,  1);
        chk("x_restart_addr", imem_addr, 0);
        @(negedge clk);
        chk("x_late_drop", count, 0);
        @(negedge clk);
        chk("x_count1", count,     1);
        chk("x_pc0",    out_pc,    0);
        chk("x_instr0", out_instr, word_at(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Fetch stage directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word requests to instruction memory, which has a fixed 1-cycle read latency. Returned words are buffered with their PC in a small FIFO, and the head entry (instruction, PC, PC+4) is presented to IF/ID. It absorbs IF/ID stalls and flushes on taken branch/jump redirects from EX.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..8.
ADDR_W, 9, instruction-memory byte-address width.
RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
clk  in  1  clock, rising edge.
Reset  in  1  asynchronous, active-high; clears all state.
imem_req  out  1  request valid this cycle.
imem_addr  out  ADDR_W  byte address = fetch_pc[ADDR_W-1:0].
imem_rdata  in  32  instruction word; valid when imem_rvalid.
imem_rvalid  in  1  response; asserted exactly 1 cycle after an accepted imem_req.
redirect  in  1  taken branch/JAL/JALR from EX; flush and refetch.
redirect_pc  in  32  new fetch target.
deq  in  1  IF/ID load enable; pops the head when out_valid=1.
out_valid  out  1  head entry valid (count != 0).
out_instr  out  32  head instruction.
out_pc  out  32  head PC (to IF/ID PCOG).
out_pc4  out  32  out_pc + 4 (to IF/ID PC4).
count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset values (asynchronous): fetch_pc=RESET_PC; pending=0; count=0; read/write pointers=0; out_valid=0; out_instr=32'h0000_0013 (NOP); out_pc=0; out_pc4=4; imem_req=0 while Reset is high.
- Credit rule: imem_req = !redirect && (count + pending) < DEPTH. The slot is reserved at issue, so a push never finds the FIFO full.
- Issue: on an edge with imem_req=1, latch pend_pc=fetch_pc, set pending=1, and fetch_pc <= fetch_pc+4 (32-bit wrap).
- Push: at the edge of the cycle where imem_rvalid=1 and pending=1, write {imem_rdata, pend_pc} at wptr. Clear pending unless a new request issues on the same edge. imem_rvalid with pending=0 is ignored.
- Pop: at an edge with deq=1 and count!=0, advance rptr. deq with count=0 is ignored.
- Push and pop on the same edge: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- Outputs are driven combinationally from the head entry, so an entry pushed at edge N is visible in cycle N+1.
- Latency:
  - req in cycle 0, rvalid in cycle 1, out_valid in cycle 2.
  - With deq held high, steady state is 1 instruction per cycle.
- Redirect (priority over issue, push and pop): at the edge, count=0, rptr=wptr=0, pending=0 (in-flight response becomes stale; its rvalid next cycle is dropped), and fetch_pc = {redirect_pc[31:2], 2'b00}. imem_req=0 during the redirect cycle; the first request at the new target goes out the following cycle.
- Redirect with an empty FIFO and nothing in flight: same behaviour, no side effects.
- Reset mid-operation: all state is cleared immediately. A memory response arriving after Reset falls is dropped because pending=0.
- No combinational path from deq to imem_req. The credit uses registered count/pending only; a freed slot is visible the next cycle.

Decomposition:
- Shared pipeline package holds: NOP_INSTR=32'h0000_0013, default DEPTH and ADDR_W, and the fetch entry layout {instr[31:0], pc[31:0]} with its 64-bit width constant.
- Sub-module fetch_fifo: synchronous FIFO with push/pop/flush, DEPTH entries, count output, head read combinational.
- The top level holds fetch_pc, pending/pend_pc, credit logic and redirect priority.

Test Plan:
- Reset release, deq=1, memory returns words W0..W3 at addresses 0,4,8,12 → imem_req high from cycle 0; out_valid first high in cycle 2 with out_instr=W0, out_pc=0, out_pc4=4; then one entry per cycle with PCs 4,8,12.
- deq=0 for 10 cycles after reset → count reaches DEPTH=4 and holds; imem_req=0 once count+pending=4; entries hold PCs 0,4,8,12 in order; raising deq resumes issue at PC 16 one cycle after the first pop.
- FIFO holding 2 entries with a request in flight, redirect=1 with redirect_pc=0x40 → next cycle count=0, out_valid=0; the stale rvalid is dropped; imem_req with addr 0x040 one cycle after redirect; first new head has out_pc=0x40.
- Misaligned redirect_pc=0x47 → fetch resumes at 0x44; out_pc=0x44, out_pc4=0x48.
- Push and deq on the same edge with count=2 → count stays 2 and head order is preserved across pointer wrap (run 3×DEPTH instructions with 1-cycle stalls every other cycle; PCs strictly +4).
- Assert Reset for 1 cycle with a request in flight and FIFO at 3 → all outputs go to reset values immediately; the late rvalid after Reset falls is not enqueued; fetch restarts at RESET_PC.
